// File: rtl/stack_alu_seq.sv
// ============================================================================
// Module      : stack_alu_seq
// Description : Pops one or two operands from an external stack, runs them
//               through a shared external ALU and pushes the result back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_op,
    output logic         cmd_ready,
    input  logic [W-1:0] stk_top,
    input  logic         stk_empty,
    output logic         stk_pop,
    output logic         stk_push,
    output logic [W-1:0] stk_wdata,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_result,
    output logic         done,
    output logic         err,
    output logic [7:0]   op_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POPB = 3'd1,
        POPA = 3'd2,
        EXEC = 3'd3,
        PUSH = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [1:0] C_OP_NOT = 2'b11;

    state_t         r_state;
    state_t         w_next;
    logic           r_ready;
    logic [W-1:0]   r_in1;
    logic [W-1:0]   r_in2;
    logic [W-1:0]   r_res;
    logic [1:0]     r_op;
    logic [7:0]     r_count;
    logic           w_accept;

    assign w_accept = cmd_valid & r_ready;

    always_comb begin
        w_next   = r_state;
        stk_pop  = 1'b0;
        stk_push = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_next = POPB;
            POPB: begin
                if (stk_empty) begin
                    w_next = ERR;
                end else begin
                    stk_pop = 1'b1;
                    w_next  = (r_op == C_OP_NOT) ? EXEC : POPA;
                end
            end
            POPA: begin
                if (stk_empty) begin
                    w_next = ERR;
                end else begin
                    stk_pop = 1'b1;
                    w_next  = EXEC;
                end
            end
            EXEC: w_next = PUSH;
            PUSH: begin
                stk_push = 1'b1;
                done     = 1'b1;
                w_next   = IDLE;
            end
            ERR: begin
                err    = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The first pop is the top (right operand); the second is second-from-top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_in1   <= '0;
            r_in2   <= '0;
            r_res   <= '0;
            r_op    <= 2'b00;
            r_count <= 8'd0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE);
            case (r_state)
                IDLE: if (w_accept) r_op <= cmd_op;
                POPB: begin
                    if (!stk_empty) begin
                        if (r_op == C_OP_NOT) begin
                            r_in1 <= stk_top;
                            r_in2 <= '0;
                        end else begin
                            r_in2 <= stk_top;
                        end
                    end
                end
                POPA: if (!stk_empty) r_in1 <= stk_top;
                EXEC: r_res <= alu_result;
                PUSH: r_count <= r_count + 8'd1;
                default: ;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign alu_in1   = r_in1;
    assign alu_in2   = r_in2;
    assign alu_op    = r_op;
    assign stk_wdata = r_res;
    assign op_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_stack_alu_seq.sv
// ============================================================================
// Module      : tb_stack_alu_seq
// Description : Directed bench with a behavioural stack and ALU around the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic [7:0] stk_top;
    logic       stk_empty;
    logic       stk_pop;
    logic       stk_push;
    logic [7:0] stk_wdata;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       done;
    logic       err;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;

    stack_alu_seq #(.W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .stk_top    (stk_top),
        .stk_empty  (stk_empty),
        .stk_pop    (stk_pop),
        .stk_push   (stk_push),
        .stk_wdata  (stk_wdata),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .done       (done),
        .err        (err),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Behavioural stack; the bench preloads it through ld_en/clr.
    logic [7:0] mem [0:7];
    logic [3:0] sp;
    int         push_total;
    logic       ld_en;
    logic       clr;
    logic [7:0] ld_data;

    assign stk_empty = (sp == 4'd0);
    assign stk_top   = (sp == 4'd0) ? 8'h00 : mem[3'(sp - 4'd1)];

    always @(posedge clk) begin
        if (clr) begin
            sp <= 4'd0;
        end else if (ld_en) begin
            mem[sp[2:0]] <= ld_data;
            sp <= sp + 4'd1;
        end else begin
            if (stk_pop) sp <= sp - 4'd1;
            if (stk_push) begin
                mem[3'(sp - (stk_pop ? 4'd1 : 4'd0))] <= stk_wdata;
                sp <= sp + 4'd1;
                push_total <= push_total + 1;
            end
        end
    end

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            2'b00: alu_result = alu_in1 + alu_in2;
            2'b01: alu_result = alu_in1 - alu_in2;
            2'b10: alu_result = alu_in1 & alu_in2;
            2'b11: alu_result = ~alu_in1;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stack_clear();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic stack_load(input logic [7:0] v);
        ld_en = 1'b1; ld_data = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Slot k is sampled 1 ns after the (k-1)th edge following the accept edge,
    // so a pulse seen in slot k takes effect at edge k.
    task automatic run_cmd(input logic [1:0] op,
                           output int pops, output int pushes,
                           output int done_k, output int err_k,
                           output logic [7:0] wdata,
                           output logic [7:0] a1_k2, output logic [7:0] a2_k2,
                           output logic [7:0] a1_k3, output logic [7:0] a2_k3,
                           output int overlap, output logic rdy_after_err);
        logic prev_err;
        pops = 0; pushes = 0; done_k = 0; err_k = 0; overlap = 0;
        wdata = 8'h00; a1_k2 = 8'h00; a2_k2 = 8'h00; a1_k3 = 8'h00; a2_k3 = 8'h00;
        rdy_after_err = 1'b0; prev_err = 1'b0;
        cmd_valid = 1'b1; cmd_op = op;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (prev_err) rdy_after_err = cmd_ready;
            prev_err = err;
            if (k == 2) begin a1_k2 = alu_in1; a2_k2 = alu_in2; end
            if (k == 3) begin a1_k3 = alu_in1; a2_k3 = alu_in2; end
            if (stk_pop) pops++;
            if (stk_push) begin pushes++; wdata = stk_wdata; end
            if (done) done_k = k;
            if (err) err_k = k;
            if (stk_pop && stk_push) overlap++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops, pushes, done_k, err_k, overlap, rdy_cnt, p0;
        logic [7:0] wdata, a1_k2, a2_k2, a1_k3, a2_k3;
        logic [7:0] pushvals [0:1];
        logic rdy_err;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        ld_en = 1'b0; clr = 1'b1; ld_data = 8'h00; push_total = 0;
        @(posedge clk); #1;
        clr = 1'b0;
        check("rst_ready", cmd_ready, 0);
        check("rst_count", op_count, 0);
        check("rst_outs", {stk_pop, stk_push, done, err}, 0);
        check("rst_wdata", stk_wdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", cmd_ready, 1);

        // sub: 0x05 - 0x03
        stack_load(8'h05); stack_load(8'h03);
        run_cmd(2'b01, pops, pushes, done_k, err_k, wdata, a1_k2, a2_k2, a1_k3, a2_k3, overlap, rdy_err);
        check("sub_pops", pops, 2);
        check("sub_pushes", pushes, 1);
        check("sub_result", wdata, 8'h02);
        check("sub_done_edge", done_k, 4);
        check("sub_in1", a1_k3, 8'h05);
        check("sub_in2", a2_k3, 8'h03);
        check("sub_count", op_count, 1);
        check("sub_overlap", overlap, 0);

        // add with wrap: 0xF0 + 0x20
        stack_clear(); stack_load(8'hF0); stack_load(8'h20);
        run_cmd(2'b00, pops, pushes, done_k, err_k, wdata, a1_k2, a2_k2, a1_k3, a2_k3, overlap, rdy_err);
        check("add_result", wdata, 8'h10);
        check("add_done_edge", done_k, 4);
        check("add_count", op_count, 2);

        // not: ~0x0F
        stack_clear(); stack_load(8'h0F);
        run_cmd(2'b11, pops, pushes, done_k, err_k, wdata, a1_k2, a2_k2, a1_k3, a2_k3, overlap, rdy_err);
        check("not_pops", pops, 1);
        check("not_in1", a1_k2, 8'h0F);
        check("not_in2", a2_k2, 8'h00);
        check("not_result", wdata, 8'hF0);
        check("not_done_edge", done_k, 3);
        check("not_count", op_count, 3);

        // underflow: and with one entry
        stack_clear(); stack_load(8'h07);
        run_cmd(2'b10, pops, pushes, done_k, err_k, wdata, a1_k2, a2_k2, a1_k3, a2_k3, overlap, rdy_err);
        check("uf_pops", pops, 1);
        check("uf_pushes", pushes, 0);
        check("uf_done", done_k, 0);
        check("uf_err_edge", err_k, 3);
        check("uf_ready_next", rdy_err, 1);
        check("uf_count", op_count, 3);
        check("uf_stack_empty", sp, 0);

        // back-to-back adds with cmd_valid held: [1,2,3] -> 5, then 6
        stack_clear(); stack_load(8'h01); stack_load(8'h02); stack_load(8'h03);
        pops = 0; pushes = 0; overlap = 0; rdy_cnt = 0;
        pushvals[0] = 8'h00; pushvals[1] = 8'h00;
        cmd_valid = 1'b1; cmd_op = 2'b00;
        @(posedge clk); #1;
        for (int m = 1; m <= 9; m++) begin
            if (cmd_ready) rdy_cnt++;
            if (stk_pop) pops++;
            if (stk_push) begin
                if (pushes < 2) pushvals[pushes] = stk_wdata;
                pushes++;
            end
            if (stk_pop && stk_push) overlap++;
            if (pushes == 2) cmd_valid = 1'b0;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("b2b_push0", pushvals[0], 8'h05);
        check("b2b_push1", pushvals[1], 8'h06);
        check("b2b_pushes", pushes, 2);
        check("b2b_pops", pops, 4);
        check("b2b_ready_gaps", rdy_cnt, 1);
        check("b2b_overlap", overlap, 0);
        check("b2b_count", op_count, 5);
        check("b2b_stack_top", stk_top, 8'h06);
        check("b2b_ready_end", cmd_ready, 1);

        // reset while in EXEC
        stack_clear(); stack_load(8'hAA); stack_load(8'h01);
        cmd_valid = 1'b1; cmd_op = 2'b01;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("exec_in1_pre", alu_in1, 8'hAA);
        p0 = push_total;
        #2 rst = 1'b1;
        #1;
        check("arst_in1", alu_in1, 0);
        check("arst_in2", alu_in2, 0);
        check("arst_op", alu_op, 0);
        check("arst_wdata", stk_wdata, 0);
        check("arst_count", op_count, 0);
        check("arst_ready", cmd_ready, 0);
        check("arst_pulses", {stk_pop, stk_push, done, err}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("arst_no_push", push_total - p0, 0);
        check("arst_stack_lost", sp, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("arst_ready_after", cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
